// File: rtl/xalu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : xalu_pkg
// Description : Op codes and class-decode helpers for the HI/LO sequencer.
//               MADD/MSUB family is only classed as long ops with XALU_MADD_EN.
// Revision    : 1.0 - initial release
// ============================================================================
package xalu_pkg;

  localparam int unsigned c_cnt_w = 6;

  typedef enum logic [3:0] {
    OP_MULT  = 4'd0,
    OP_MULTU = 4'd1,
    OP_DIV   = 4'd2,
    OP_DIVU  = 4'd3,
    OP_MTHI  = 4'd4,
    OP_MTLO  = 4'd5,
    OP_MFHI  = 4'd6,
    OP_MFLO  = 4'd7,
    OP_MADD  = 4'd8,
    OP_MADDU = 4'd9,
    OP_MSUB  = 4'd10,
    OP_MSUBU = 4'd11
  } xalu_op_e;

  function automatic logic is_mult_class(input logic [3:0] op);
    logic r;
    r = 1'b0;
    case (op)
      OP_MULT, OP_MULTU: r = 1'b1;
`ifdef XALU_MADD_EN
      OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: r = 1'b1;
`endif
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic is_div_class(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_signed_op(input logic [3:0] op);
    return (op == OP_MULT) || (op == OP_MADD) || (op == OP_MSUB) || (op == OP_DIV);
  endfunction

endpackage
`default_nettype wire

// File: rtl/xalu_div.sv
`default_nettype none
// ============================================================================
// Module      : xalu_div
// Description : Combinational signed/unsigned divider with MIPS-style
//               divide-by-zero and overflow results.
// Revision    : 1.0 - initial release
// ============================================================================
module xalu_div #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             is_signed,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam logic [WIDTH-1:0] c_min_neg = {1'b1, {(WIDTH-1){1'b0}}};

  logic             neg_n;
  logic             neg_d;
  logic [WIDTH-1:0] mag_n;
  logic [WIDTH-1:0] mag_d;
  logic [WIDTH-1:0] uq;
  logic [WIDTH-1:0] ur;

  always_comb begin
    neg_n = is_signed & dividend[WIDTH-1];
    neg_d = is_signed & divisor[WIDTH-1];
    mag_n = neg_n ? -dividend : dividend;
    mag_d = neg_d ? -divisor  : divisor;
    uq    = mag_n / mag_d;
    ur    = mag_n % mag_d;

    if (divisor == '0) begin
      quotient  = '1;
      remainder = dividend;
    end else if (is_signed && (dividend == c_min_neg) && (divisor == '1)) begin
      quotient  = dividend;
      remainder = '0;
    end else begin
      // Truncating division: remainder follows the dividend's sign.
      quotient  = (neg_n ^ neg_d) ? -uq : uq;
      remainder = neg_n ? -ur : ur;
    end
  end

endmodule
`default_nettype wire

// File: rtl/xalu_seq.sv
`default_nettype none
// ============================================================================
// Module      : xalu_seq
// Description : Multi-cycle HI/LO multiply/divide sequencer with fixed,
//               counter-driven latency. Define XALU_MADD_EN for MADD/MSUB ops.
// Revision    : 1.0 - initial release
// ============================================================================
module xalu_seq
  import xalu_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [c_cnt_w-1:0] cnt_q, cnt_d;
  logic [3:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;

  logic [2*WIDTH-1:0] ext_a;
  logic [2*WIDTH-1:0] ext_b;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] mult_res;
  logic [2*WIDTH-1:0] result;
  logic [WIDTH-1:0]   div_q;
  logic [WIDTH-1:0]   div_r;
  logic               op_signed;

  assign op_signed = is_signed_op(op_q);

  // Sign- or zero-extend so one 2*WIDTH multiply covers both flavours.
  assign ext_a = op_signed ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
  assign ext_b = op_signed ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
  assign prod  = ext_a * ext_b;

`ifdef XALU_MADD_EN
  always_comb begin
    mult_res = prod;
    case (op_q)
      OP_MADD, OP_MADDU: mult_res = {hi_q, lo_q} + prod;
      OP_MSUB, OP_MSUBU: mult_res = {hi_q, lo_q} - prod;
      default:           mult_res = prod;
    endcase
  end
`else
  assign mult_res = prod;
`endif

  xalu_div #(
    .WIDTH(WIDTH)
  ) u_div (
    .dividend (a_q),
    .divisor  (b_q),
    .is_signed(op_signed),
    .quotient (div_q),
    .remainder(div_r)
  );

  assign result = is_div_class(op_q) ? {div_r, div_q} : mult_res;

  always_comb begin
    hi_d   = hi_q;
    lo_d   = lo_q;
    busy_d = busy_q;
    done_d = 1'b0;
    cnt_d  = cnt_q;
    op_d   = op_q;
    a_d    = a_q;
    b_d    = b_q;

    if (busy_q) begin
      if (flush) begin
        busy_d = 1'b0;
        cnt_d  = '0;
      end else if (cnt_q == c_cnt_w'(1)) begin
        busy_d = 1'b0;
        cnt_d  = '0;
        done_d = 1'b1;
        hi_d   = result[2*WIDTH-1:WIDTH];
        lo_d   = result[WIDTH-1:0];
      end else begin
        cnt_d  = cnt_q - c_cnt_w'(1);
      end
    end else if (start && !flush) begin
      if (op == OP_MTHI) begin
        hi_d = a;
      end else if (op == OP_MTLO) begin
        lo_d = a;
      end else if (is_mult_class(op) || is_div_class(op)) begin
        op_d   = op;
        a_d    = a;
        b_d    = b;
        busy_d = 1'b1;
        cnt_d  = is_div_class(op) ? c_cnt_w'(DIV_CYCLES) : c_cnt_w'(MULT_CYCLES);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      hi_q   <= '0;
      lo_q   <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      cnt_q  <= '0;
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
    end else begin
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      busy_q <= busy_d;
      done_q <= done_d;
      cnt_q  <= cnt_d;
      op_q   <= op_d;
      a_q    <= a_d;
      b_q    <= b_d;
    end
  end

  always_comb begin
    rd_data = '0;
    if (op == OP_MFHI) begin
      rd_data = hi_q;
    end else if (op == OP_MFLO) begin
      rd_data = lo_q;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_xalu_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_xalu_seq
// Description : Scoreboard bench for xalu_seq; expected HI/LO results are
//               queued at issue and compared by a monitor on each done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_xalu_seq;
  import xalu_pkg::*;

  localparam int W = 32;

  logic         clk   = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic         flush = 1'b0;
  logic [3:0]   op    = 4'hF;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic [W-1:0] rd_data;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [63:0] sb_q[$];
  logic [63:0] mon_exp;

  always #5 clk = ~clk;

  xalu_seq #(
    .WIDTH      (W),
    .MULT_CYCLES(5),
    .DIV_CYCLES (10)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo),
    .rd_data(rd_data)
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    tick();
    start = 1'b0;
    op    = 4'hF;
  endtask

  task automatic run_long(input string nm, input logic [3:0] o, input logic [W-1:0] x,
                          input logic [W-1:0] y, input int lat, input logic [63:0] exp);
    int n;
    n = 0;
    sb_q.push_back(exp);
    issue(o, x, y);
    while (busy === 1'b1 && n < 200) begin
      tick();
      n++;
    end
    check({nm, "_busy_len"}, 64'(n), 64'(lat));
    check({nm, "_done"}, 64'(done), 64'd1);
    tick();
    check({nm, "_done_pulse"}, 64'(done), 64'd0);
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset && done === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 hi=0x%0h lo=0x%0h, expected no done", hi, lo);
      end else begin
        mon_exp = sb_q.pop_front();
        check("result", {hi, lo}, mon_exp);
      end
    end
  end

  initial begin
    int nb;

    reset = 1'b0;
    repeat (2) tick();
    check("reset_hilo", {hi, lo}, 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    reset = 1'b1;
    tick();

    run_long("mult",   OP_MULT,  32'hFFFF_FFFD, 32'd7,         5,  64'hFFFFFFFF_FFFFFFEB);
    run_long("multu",  OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5,  64'hFFFFFFFE_00000001);
    run_long("div",    OP_DIV,   32'hFFFF_FFF9, 32'd2,         10, 64'hFFFFFFFF_FFFFFFFD);
    run_long("divu0",  OP_DIVU,  32'd7,         32'd0,         10, 64'h00000007_FFFFFFFF);
    run_long("div_ov", OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 10, 64'h00000000_80000000);
    run_long("div_nd", OP_DIV,   32'd7,         32'hFFFF_FFFE, 10, 64'h00000001_FFFFFFFD);
    run_long("divu",   OP_DIVU,  32'd100,       32'd7,         10, 64'h00000002_0000000E);
    run_long("div0s",  OP_DIV,   32'hFFFF_FFFB, 32'd0,         10, 64'hFFFFFFFB_FFFFFFFF);

    issue(OP_MTHI, 32'd5, 32'd0);
    check("mthi_hi", 64'(hi), 64'd5);
    check("mthi_busy", 64'(busy), 64'd0);
    issue(OP_MTLO, 32'd1, 32'd0);
    check("mtlo_hilo", {hi, lo}, 64'h00000005_00000001);
    op = OP_MFHI; #1;
    check("rd_mfhi", 64'(rd_data), 64'd5);
    op = OP_MFLO; #1;
    check("rd_mflo", 64'(rd_data), 64'd1);
    op = OP_MULT; #1;
    check("rd_other", 64'(rd_data), 64'd0);
    op = 4'hF;

    issue(4'hC, 32'd9, 32'd9);
    check("undef_busy", 64'(busy), 64'd0);
    check("undef_hilo", {hi, lo}, 64'h00000005_00000001);

`ifdef XALU_MADD_EN
    run_long("madd",  OP_MADD,  32'd2,         32'd3, 5, 64'h00000005_00000007);
    run_long("msub",  OP_MSUB,  32'd1,         32'd8, 5, 64'h00000004_FFFFFFFF);
    run_long("maddu", OP_MADDU, 32'hFFFF_FFFF, 32'd2, 5, 64'h00000006_FFFFFFFD);
`else
    issue(OP_MADD, 32'd2, 32'd3);
    nb = 0;
    for (int i = 0; i < 8; i++) begin
      if (busy === 1'b1) nb++;
      tick();
    end
    check("madd_off_busy", 64'(nb), 64'd0);
    check("madd_off_hilo", {hi, lo}, 64'h00000005_00000001);
`endif

    issue(OP_MTHI, 32'h11, 32'd0);
    issue(OP_MTLO, 32'h22, 32'd0);
    sb_q.push_back(64'd12);
    issue(OP_MULTU, 32'd3, 32'd4);
    for (int i = 0; i < 5; i++) begin
      start = 1'b1;
      op    = (i % 2 == 0) ? OP_MFHI : OP_MFLO;
      #1;
      check("rd_while_busy", 64'(rd_data), (i % 2 == 0) ? 64'h11 : 64'h22);
      tick();
    end
    start = 1'b0;
    op    = OP_MFLO;
    #1;
    check("rd_after_done", 64'(rd_data), 64'd12);
    check("busy_after_done", 64'(busy), 64'd0);
    op = 4'hF;
    tick();

    issue(OP_MULTU, 32'd5, 32'd6);
    tick();
    start = 1'b1;
    op    = OP_DIV;
    a     = 32'd9;
    b     = 32'd2;
    tick();
    start = 1'b0;
    op    = 4'hF;
    flush = 1'b1;
    check("flush_busy_before", 64'(busy), 64'd1);
    tick();
    flush = 1'b0;
    check("flush_busy_after", 64'(busy), 64'd0);
    check("flush_hilo", {hi, lo}, 64'd12);
    repeat (12) tick();
    check("flush_no_restart", 64'(busy), 64'd0);

    start = 1'b1;
    flush = 1'b1;
    op    = OP_MTHI;
    a     = 32'hDEAD;
    tick();
    start = 1'b0;
    flush = 1'b0;
    op    = 4'hF;
    check("flush_start_hilo", {hi, lo}, 64'd12);

    issue(OP_DIV, 32'd100, 32'd3);
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("rst_mid_hilo", {hi, lo}, 64'd0);
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_done", 64'(done), 64'd0);
    reset = 1'b1;
    repeat (15) tick();
    check("rst_mid_after", {63'd0, busy}, 64'd0);

    check("sb_drain", 64'(sb_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/xalu_seq.md
XALU_SEQ -- requirements
Module: xalu_seq

Interface
REQ-001 Parameter WIDTH, default 32: operand, HI and LO width in bits.
REQ-002 Parameter MULT_CYCLES, default 5: busy cycles for mult-class ops; legal range 1..63.
REQ-003 Parameter DIV_CYCLES, default 10: busy cycles for div-class ops; legal range 1..63.
REQ-004 clk  input  1  sole clock; all state changes on the rising edge.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 start  input  1  op request, qualified by !busy.
REQ-007 op  input  4  operation code from xalu_pkg: MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI, MFLO, MADD, MADDU, MSUB, MSUBU.
REQ-008 a, b  input  WIDTH  rs and rt operands.
REQ-009 flush  input  1  aborts an in-flight op.
REQ-010 busy  output  1  long op in flight; the pipeline controller stalls on it.
REQ-011 done  output  1  one-cycle pulse on completion of a long op.
REQ-012 hi, lo  output  WIDTH  architectural HI and LO registers.
REQ-013 rd_data  output  WIDTH  combinational read port: hi when op==MFHI, lo when op==MFLO, else 0.

Function
REQ-014 A request shall be accepted at an edge where start=1, busy=0 and flush=0; start at any other time shall be ignored.
REQ-015 MTHI/MTLO shall write a into hi/lo at the accepting edge, leave busy at 0 and not pulse done.
REQ-016 MFHI/MFLO shall modify no state.
REQ-017 Accepted MULT-class and DIV-class ops shall latch a, b and op, load a down-counter with the op's latency L, and set busy=1 from the next cycle.
REQ-018 busy shall stay high for exactly L cycles.
REQ-019 At the edge ending the last busy cycle, hi/lo shall take the result, busy shall fall, and done shall be 1 for the following cycle only.
REQ-020 MULT/MULTU shall form the 2*WIDTH-bit signed/unsigned product, with {hi,lo} = product.
REQ-021 MADD/MADDU shall compute {hi,lo} = {hi,lo} + product; MSUB/MSUBU shall compute {hi,lo} = {hi,lo} - product. Arithmetic is modulo 2^(2*WIDTH) and uses the {hi,lo} value sampled at completion.
REQ-022 DIV/DIVU shall produce lo = quotient and hi = remainder. Signed division truncates toward zero; the remainder takes the sign of the dividend.
REQ-023 Divide by zero shall give lo = all ones and hi = a, with no exception.
REQ-024 Signed overflow (a = most-negative value, b = -1) shall give lo = a and hi = 0.
REQ-025 flush=1 while busy shall abort the op at that edge: hi/lo unchanged, busy=0 in the next cycle, no done pulse.
REQ-026 flush and start asserted together shall resolve in favour of flush; no request is accepted.
REQ-027 Undefined op codes shall be accepted as no-ops.

Reset
REQ-028 At an edge with reset=0, the block shall set hi=0, lo=0, busy=0, done=0 and counter=0.
REQ-029 Reset shall abort any in-flight op without writing HI/LO and shall take priority over start and flush.

Configuration
REQ-030 Macro XALU_MADD_EN shall compile in MADD, MADDU, MSUB and MSUBU.
REQ-031 Without XALU_MADD_EN, those four codes shall behave as no-ops (REQ-027), and the accumulate adder shall be absent from the netlist.

Structure
REQ-032 Package xalu_pkg shall hold the op-code constants and the MULT/DIV class-decode functions.
REQ-033 Sub-module xalu_div shall implement signed/unsigned division, including the REQ-023 and REQ-024 special cases, as a combinational unit. xalu_seq shall only sample its output on the completion edge.
REQ-034 Latency shall come from the counter, not from the datapath depth.

Verification
REQ-035 With WIDTH=32 and MULT_CYCLES=5: MULT a=-3, b=7 -> busy high for exactly 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFEB, and done high for 1 cycle.
REQ-036 With DIV_CYCLES=10: DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=7, b=0 -> lo=0xFFFFFFFF, hi=7.
REQ-037 MTHI 5, MTLO 1, then MADD a=2, b=3 -> hi=5, lo=7. With XALU_MADD_EN undefined -> hi=5, lo=1, busy never asserts.
REQ-038 MULTU started; start+DIV asserted in busy cycle 2; flush in busy cycle 3 -> second request ignored, hi/lo unchanged, no done, busy=0 in the next cycle.
REQ-039 Reset pulled low mid-DIV -> hi=lo=0, busy=0 after the edge, and no done afterwards.
REQ-040 MFHI/MFLO issued while busy -> rd_data returns the pre-op hi/lo until the completion edge.
